// File: rtl/dmem_pkg.sv
// Shared types and size decode for the MEM-stage data-memory access controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // StoreType codes; also reused as the generic access-size code
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LB  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  function automatic logic [1:0] load_size(input logic [2:0] lt);
    case (lt)
      LT_LH, LT_LHU: return SZ_HALF;
      LT_LB, LT_LBU: return SZ_BYTE;
      default:       return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_gen.sv
// Byte-lane enables, replicated write data and alignment check for one access.
module dmem_lane_gen
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  // The reserved size code falls through to word behaviour.
  always_comb begin
    be_o         = 4'b1111;
    wdata_o      = data_i;
    misaligned_o = (addr_lo_i != 2'b00);
    case (size_i)
      SZ_HALF: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      SZ_BYTE: begin
        be_o         = 4'b0001 << addr_lo_i;
        wdata_o      = {4{data_i[7:0]}};
        misaligned_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack bus access per load/store and
// stalls the pipeline until it completes, is aborted by timeout, or is rejected as misaligned.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  StoreTypeM,
  input  logic [2:0]  LoadTypeM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        FlushM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MemErrM
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              acc;
  logic [1:0]        size;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic              lane_mis;

  assign acc  = (MemReadM | MemWriteM) & ~FlushM;
  // A store takes precedence when both strobes are raised.
  assign size = MemWriteM ? StoreTypeM : load_size(LoadTypeM);

  dmem_lane_gen u_lane_gen (
    .size_i       (size),
    .addr_lo_i    (ALUOutM[1:0]),
    .data_i       (WriteDataM),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_mis)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    StallM  = 1'b0;
    MemErrM = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && lane_mis) begin
          MemErrM = 1'b1;
        end else if (acc) begin
          StallM  = 1'b1;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALUOutM[31:2], 2'b00};
          be_d    = MemWriteM ? lane_be : 4'b1111;
          wdata_d = MemWriteM ? lane_wdata : 32'h0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        StallM = 1'b1;
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        MemErrM = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed and random access sequences checked against a transaction-level model of the controller.
module tb_dmem_access_ctrl;

  localparam int T = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0, FlushM = 1'b0;
  logic [1:0]  StoreTypeM = 2'b00;
  logic [2:0]  LoadTypeM = 3'b000;
  logic [31:0] ALUOutM = 32'h0, WriteDataM = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_req, mem_we, StallM, MemErrM;
  logic [31:0] mem_addr, mem_wdata, ReadDataM;
  logic [3:0]  mem_be;

  int          total = 0;
  int          bad = 0;
  logic [31:0] rd_exp = 32'h0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .StoreTypeM (StoreTypeM),
    .LoadTypeM  (LoadTypeM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .FlushM     (FlushM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .MemErrM    (MemErrM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes as seen by the model
  function automatic int ref_bytes(input bit wr, input logic [1:0] st, input logic [2:0] lt);
    if (wr) return (st == 2'b01) ? 2 : (st == 2'b10) ? 1 : 4;
    case (lt)
      3'd1, 3'd3: return 2;
      3'd2, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  task automatic clear_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; FlushM = 1'b0;
    StoreTypeM = 2'b00; LoadTypeM = 3'b000; ALUOutM = 32'h0; WriteDataM = 32'h0;
  endtask

  // Starts at posedge+1 in IDLE, ends at posedge+1 in IDLE.
  // ack_k: BUSY cycle (1-based) in which mem_ack pulses; outside 1..T means no ack.
  task automatic do_access(input bit rd, input bit wr, input bit fl, input logic [1:0] st,
                           input logic [2:0] lt, input logic [31:0] addr, input logic [31:0] data,
                           input int ack_k, input logic [31:0] rdata);
    int n, nb, stalls;
    bit acc, mis, to;
    logic [3:0]  be_e;
    logic [31:0] wd_e;
    n   = ref_bytes(wr, st, lt);
    acc = (rd || wr) && !fl;
    mis = acc && ((int'(addr[1:0]) % n) != 0);
    to  = !(ack_k >= 1 && ack_k <= T);
    nb  = to ? T : ack_k;
    be_e = wr ? 4'(((1 << n) - 1) << int'(addr[1:0])) : 4'hF;
    wd_e = (n == 4) ? data : (n == 2) ? data[15:0] * 32'h0001_0001 : data[7:0] * 32'h0101_0101;

    MemReadM = rd; MemWriteM = wr; FlushM = fl; StoreTypeM = st; LoadTypeM = lt;
    ALUOutM = addr; WriteDataM = data; mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    @(negedge clk);
    chk("idle_stall", StallM, 32'(acc && !mis));
    chk("idle_err", MemErrM, 32'(mis));
    chk("idle_req", mem_req, 0);
    stalls = int'(StallM);

    if (!acc || mis) begin
      @(posedge clk); #1;
      clear_inputs(); mem_ack = 1'b0;
      @(negedge clk);
      chk("reject_err_clear", MemErrM, 0);
      chk("reject_no_req", mem_req, 0);
      chk("reject_no_stall", StallM, 0);
      @(posedge clk); #1;
    end else begin
      for (int k = 1; k <= nb; k++) begin
        @(posedge clk); #1;
        mem_ack   = (k == ack_k);
        mem_rdata = (k == ack_k) ? rdata : $urandom;
        FlushM    = 1'($urandom % 2);
        @(negedge clk);
        stalls += int'(StallM);
        chk("busy_req", mem_req, 1);
        chk("busy_we", mem_we, 32'(wr));
        chk("busy_addr", mem_addr, addr & ~32'h3);
        chk("busy_be", mem_be, 32'(be_e));
        if (wr) chk("busy_wdata", mem_wdata, wd_e);
      end
      @(posedge clk); #1;
      mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
      if (to) rd_exp = 32'h0;
      else if (!wr) rd_exp = rdata;
      @(negedge clk);
      stalls += int'(StallM);
      chk("done_req", mem_req, 0);
      chk("done_rdata", ReadDataM, rd_exp);
      chk("done_err", MemErrM, 32'(to));
      chk("stall_cycles", 32'(stalls), 32'(1 + nb));
      @(posedge clk); #1;
      clear_inputs(); mem_ack = 1'b0;
      @(negedge clk);
      chk("after_req", mem_req, 0);
      chk("after_stall", StallM, 0);
      chk("after_err", MemErrM, 0);
      chk("after_rdata", ReadDataM, rd_exp);
      @(posedge clk); #1;
    end
    $display("access rd=%0b wr=%0b fl=%0b addr=%h ack_k=%0d -> stalls=%0d err=%0b rdata=%h",
             rd, wr, fl, addr, ack_k, stalls, to && acc && !mis, ReadDataM);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", ReadDataM, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_err", MemErrM, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Spec scenarios
    do_access(1, 0, 0, 2'b00, 3'd0, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
    do_access(0, 1, 0, 2'b10, 3'd0, 32'h0000_0203, 32'h0000_00A5, 5, 32'h0);
    do_access(0, 1, 0, 2'b01, 3'd0, 32'h0000_0101, 32'h0000_1234, 1, 32'h0);
    do_access(1, 0, 0, 2'b00, 3'd0, 32'h0000_0104, 32'h0, 0, 32'h0);

    // Reset in the middle of BUSY, then a late ack
    MemReadM = 1'b1; LoadTypeM = 3'd0; ALUOutM = 32'h0000_0300;
    @(negedge clk);
    chk("rstmid_idle_stall", StallM, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_busy_req", mem_req, 1);
    #1;
    rst = 1'b1; clear_inputs();
    #1;
    chk("rstmid_req", mem_req, 0);
    chk("rstmid_stall", StallM, 0);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_be", mem_be, 0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    rd_exp = 32'h0;
    @(negedge clk);
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_stall", StallM, 0);
    chk("late_ack_rdata", ReadDataM, rd_exp);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    $display("reset mid-busy: req=%0b stall=%0b rdata=%h", mem_req, StallM, ReadDataM);

    // Back-to-back, flush, precedence and boundaries
    do_access(1, 0, 0, 2'b00, 3'd0, 32'h0000_0200, 32'h0, 2, 32'hCAFE_F00D);
    do_access(0, 1, 0, 2'b00, 3'd0, 32'h0000_0204, 32'h1122_3344, 1, 32'h0);
    do_access(0, 1, 1, 2'b00, 3'd0, 32'h0000_0208, 32'h0000_0055, 1, 32'h0);
    do_access(1, 1, 0, 2'b01, 3'd0, 32'h0000_030E, 32'h0000_BEEF, T, 32'h7777_7777);
    do_access(0, 1, 0, 2'b11, 3'd0, 32'h0000_0410, 32'h89AB_CDEF, 3, 32'h0);
    do_access(1, 0, 0, 2'b00, 3'd2, 32'h0000_0413, 32'h0, T + 1, 32'h1);
    do_access(1, 0, 0, 2'b00, 3'd0, 32'h0000_0102, 32'h0, 1, 32'h0);
    do_access(0, 1, 0, 2'b10, 3'd0, 32'h0000_0501, 32'h0000_003C, 2, 32'h0);
    do_access(1, 0, 0, 2'b00, 3'd3, 32'h0000_0602, 32'h0, 1, 32'hA1B2_C3D4);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 2 == 1) a[1:0] = 2'b00;
      do_access(1'($urandom % 2), 1'($urandom % 2), ($urandom % 5) == 0,
                2'($urandom % 4), 3'($urandom % 5), a, $urandom,
                int'($urandom_range(0, T + 2)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
